// File: rtl/mem_wb_stage_pkg.sv
// Shared opcode encodings and the register-writing opcode list for the W stage
// and the hazard unit's forwarding path.
package mem_wb_stage_pkg;

  localparam int OPC_W = 7;

  localparam logic [OPC_W-1:0] OP_NOP   = 7'h00;
  localparam logic [OPC_W-1:0] OP_LOAD  = 7'h03;
  localparam logic [OPC_W-1:0] OP_I     = 7'h13;
  localparam logic [OPC_W-1:0] OP_AUIPC = 7'h17;
  localparam logic [OPC_W-1:0] OP_S     = 7'h23;
  localparam logic [OPC_W-1:0] OP_R     = 7'h33;
  localparam logic [OPC_W-1:0] OP_LUI   = 7'h37;
  localparam logic [OPC_W-1:0] OP_B     = 7'h63;
  localparam logic [OPC_W-1:0] OP_JALR  = 7'h67;
  localparam logic [OPC_W-1:0] OP_JAL   = 7'h6F;

  // Unknown opcodes fall through to "no write" so stray encodings never touch the regfile.
  function automatic logic writes_rd(input logic [OPC_W-1:0] opcode);
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: writes_rd = 1'b1;
      default:                                                writes_rd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wb_stage_wb_select.sv
// Writeback value select: load data, link address (pc+4) or ALU result.
// Purely combinational so the forwarding path can reuse it unregistered.
module wb_select
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [OPC_W-1:0] opcode_i,
  input  logic [XLEN-1:0]  val_e_i,
  input  logic [XLEN-1:0]  val_m_i,
  input  logic [XLEN-1:0]  pc_i,
  output logic [XLEN-1:0]  wdata_o,
  output logic             writes_rd_o
);

  logic [XLEN-1:0] link_addr;

  // Link address wraps modulo 2^XLEN by construction of the adder width.
  assign link_addr = pc_i + XLEN'(4);

  always_comb begin
    wdata_o = val_e_i;
    case (opcode_i)
      OP_LOAD:         wdata_o = val_m_i;
      OP_JAL, OP_JALR: wdata_o = link_addr;
      default:         wdata_o = val_e_i;
    endcase
  end

  assign writes_rd_o = writes_rd(opcode_i);

endmodule

// File: rtl/mem_wb_stage.sv
// W-stage pipeline register, regfile write-port generation and retired-instruction counter.
// Writeback outputs are combinational from the W registers.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int              XLEN   = 32,
  parameter int              CNT_W  = 64,
  parameter logic [XLEN-1:0] RST_PC = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             W_stall_i,
  input  logic             W_bubble_i,
  input  logic             M_valid_i,
  input  logic [OPC_W-1:0] M_opcode_i,
  input  logic [4:0]       M_rd_i,
  input  logic [XLEN-1:0]  M_pc_i,
  input  logic [XLEN-1:0]  M_valE_i,
  input  logic [XLEN-1:0]  m_valM_i,
  output logic             W_valid_o,
  output logic [OPC_W-1:0] W_opcode_o,
  output logic [4:0]       W_rd_o,
  output logic [XLEN-1:0]  W_pc_o,
  output logic             w_wen_o,
  output logic [4:0]       w_rd_o,
  output logic [XLEN-1:0]  w_wdata_o,
  output logic [CNT_W-1:0] w_instret_o
);

  logic [XLEN-1:0] val_e_w;
  logic [XLEN-1:0] val_m_w;
  logic [XLEN-1:0] sel_wdata;
  logic            sel_writes_rd;
  logic            capture;

  // Bubble outranks stall; only a plain capture edge advances the pipeline.
  assign capture = !W_bubble_i && !W_stall_i;

  // ---- M -> W register boundary ----
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      W_valid_o  <= 1'b0;
      W_opcode_o <= OP_NOP;
      W_rd_o     <= '0;
      W_pc_o     <= RST_PC;
      val_e_w    <= '0;
      val_m_w    <= '0;
    end else if (W_bubble_i) begin
      W_valid_o  <= 1'b0;
      W_opcode_o <= OP_NOP;
      W_rd_o     <= '0;
      W_pc_o     <= RST_PC;
      val_e_w    <= '0;
      val_m_w    <= '0;
    end else if (capture) begin
      W_valid_o  <= M_valid_i;
      W_opcode_o <= M_opcode_i;
      W_rd_o     <= M_rd_i;
      W_pc_o     <= M_pc_i;
      val_e_w    <= M_valE_i;
      val_m_w    <= m_valM_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      w_instret_o <= '0;
    end else if (capture && M_valid_i) begin
      w_instret_o <= w_instret_o + CNT_W'(1);
    end
  end

  wb_select #(
    .XLEN(XLEN)
  ) u_wb_select (
    .opcode_i    (W_opcode_o),
    .val_e_i     (val_e_w),
    .val_m_i     (val_m_w),
    .pc_i        (W_pc_o),
    .wdata_o     (sel_wdata),
    .writes_rd_o (sel_writes_rd)
  );

  // ---- W writeback port ----
  assign w_wen_o   = W_valid_o && sel_writes_rd && (W_rd_o != 5'd0);
  assign w_rd_o    = w_wen_o ? W_rd_o : 5'd0;
  assign w_wdata_o = W_valid_o ? sel_wdata : '0;

endmodule
